// File: rtl/inst_axi_bridge.sv
// Instruction-fetch to AXI read bridge.
// Accepts single-word fetch requests, issues one AR at a time, tracks up to
// MAX_OUT accepted-but-unanswered requests and returns R beats in order.
module inst_axi_bridge #(
    parameter logic [3:0]  ARID    = 4'd0,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,

    // Fetch side
    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_bus_err,

    // AXI read address channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // AXI read data channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    // Performance counter
    output logic [31:0] perfcnt_ar_stall
);

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_e;

    localparam logic [1:0] MAX_OUT_W = 2'(MAX_OUT);

    ar_state_e   r_state;
    ar_state_e   w_state_nxt;

    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [31:0] r_araddr;
    logic [3:0]  r_arcache;
    logic [31:0] r_perf;
    logic        r_init;

    logic        w_block;
    logic        w_data_ok;
    logic        w_addr_ok;
    logic        w_arvalid;
    logic        w_ar_hs;
    logic        w_unused;

    // Single ID with in-order return: rid carries no information here.
    assign w_unused = ^{rid, rresp[0]};

    // Handshake outputs stay low during reset and for one cycle after it.
    assign w_block = reset | r_init;

    assign w_data_ok = rvalid && rlast && (r_cnt != 2'd0) && !w_block;
    assign w_ar_hs   = w_arvalid && arready;

    // Marks the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_init <= 1'b1;
        end else begin
            r_init <= 1'b0;
        end
    end

    // AR slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= AR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // AR slot next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            AR_IDLE: begin
                if (w_addr_ok) begin
                    w_state_nxt = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (w_ar_hs) begin
                    w_state_nxt = AR_IDLE;
                end
            end
            default: w_state_nxt = AR_IDLE;
        endcase
    end

    // AR slot outputs; a returning beat frees a slot in the same cycle.
    always_comb begin
        w_arvalid = 1'b0;
        w_addr_ok = 1'b0;
        unique case (r_state)
            AR_IDLE: begin
                w_addr_ok = inst_req && !w_block && ((r_cnt < MAX_OUT_W) || w_data_ok);
            end
            AR_BUSY: begin
                w_arvalid = 1'b1;
            end
            default: begin
                w_arvalid = 1'b0;
                w_addr_ok = 1'b0;
            end
        endcase
    end

    // Outstanding request counter next value.
    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case ({w_addr_ok, w_data_ok})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Outstanding counter and captured AR payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 2'd0;
            r_araddr  <= 32'd0;
            r_arcache <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_addr_ok) begin
                r_araddr  <= inst_addr;
                r_arcache <= inst_cache ? 4'b1111 : 4'b0000;
            end
        end
    end

    // Count AR back-pressure cycles, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf <= 32'd0;
        end else if (w_arvalid && !arready) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign inst_addr_ok     = w_addr_ok;
    assign inst_data_ok     = w_data_ok;
    assign inst_rdata       = rdata;
    assign inst_bus_err     = w_data_ok && rresp[1];

    assign arid             = ARID;
    assign araddr           = r_araddr;
    assign arlen            = 8'd0;
    assign arsize           = 3'd2;
    assign arburst          = 2'b01;
    assign arcache          = r_arcache;
    assign arprot           = 3'b100;
    assign arvalid          = w_arvalid;

    // Beats arriving with nothing outstanding are left unconsumed.
    assign rready           = (r_cnt != 2'd0) && !w_block;

    assign perfcnt_ar_stall = r_perf;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge with an in-order read-data scoreboard.
module tb_inst_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic        inst_cache;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] perfcnt_ar_stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_dok   = 0;
    logic [32:0] sb_q[$];
    logic [32:0] mon_e;

    always #5 clk = ~clk;

    inst_axi_bridge #(
        .ARID    (4'hA),
        .MAX_OUT (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_req         (inst_req),
        .inst_cache       (inst_cache),
        .inst_addr        (inst_addr),
        .inst_addr_ok     (inst_addr_ok),
        .inst_data_ok     (inst_data_ok),
        .inst_rdata       (inst_rdata),
        .inst_bus_err     (inst_bus_err),
        .arid             (arid),
        .araddr           (araddr),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .arcache          (arcache),
        .arprot           (arprot),
        .arvalid          (arvalid),
        .arready          (arready),
        .rid              (rid),
        .rdata            (rdata),
        .rresp            (rresp),
        .rlast            (rlast),
        .rvalid           (rvalid),
        .rready           (rready),
        .perfcnt_ar_stall (perfcnt_ar_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: every data_ok must match the oldest expected beat.
    always @(negedge clk) begin
        if (inst_data_ok === 1'b1) begin
            n_dok++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_data_ok", 32'(inst_data_ok), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_rdata", inst_rdata, mon_e[31:0]);
                chk("sb_bus_err", 32'(inst_bus_err), 32'(mon_e[32]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        inst_req   = 1'b1;
        inst_cache = 1'b0;
        inst_addr  = 32'h1234_5678;
        arready    = 1'b0;
        rid        = 4'd0;
        rdata      = 32'h0;
        rresp      = 2'b00;
        rlast      = 1'b1;
        rvalid     = 1'b1;

        // Reset: handshakes held low while reset is asserted
        smp();
        chk("rst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        cyc();
        smp();
        cyc();
        reset = 1'b0;
        smp();
        chk("post_rst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("post_rst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("post_rst_rready", 32'(rready), 32'd0);
        chk("post_rst_arvalid", 32'(arvalid), 32'd0);
        chk("post_rst_araddr", araddr, 32'd0);
        chk("post_rst_arcache", 32'(arcache), 32'd0);
        chk("post_rst_perf", perfcnt_ar_stall, 32'd0);
        chk("post_rst_cnt", 32'(dut.r_cnt), 32'd0);
        cyc();
        inst_req = 1'b0;
        rvalid   = 1'b0;
        smp();

        // Single fetch
        cyc();
        inst_req   = 1'b1;
        inst_addr  = 32'h1FC0_0000;
        inst_cache = 1'b0;
        arready    = 1'b1;
        smp();
        chk("sf_addr_ok", 32'(inst_addr_ok), 32'd1);
        cyc();
        inst_req = 1'b0;
        smp();
        chk("sf_arvalid", 32'(arvalid), 32'd1);
        chk("sf_araddr", araddr, 32'h1FC0_0000);
        chk("sf_arcache", 32'(arcache), 32'd0);
        chk("sf_arid", 32'(arid), 32'hA);
        chk("sf_arlen", 32'(arlen), 32'd0);
        chk("sf_arsize", 32'(arsize), 32'd2);
        chk("sf_arburst", 32'(arburst), 32'd1);
        chk("sf_arprot", 32'(arprot), 32'd4);
        cyc();
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 32'h3C1A_BFC0;
        rresp  = 2'b00;
        sb_q.push_back({1'b0, 32'h3C1A_BFC0});
        smp();
        chk("sf_data_ok", 32'(inst_data_ok), 32'd1);
        chk("sf_rready", 32'(rready), 32'd1);
        chk("sf_arvalid_low", 32'(arvalid), 32'd0);
        cyc();
        rvalid = 1'b0;
        smp();
        chk("sf_cnt_zero", 32'(dut.r_cnt), 32'd0);
        chk("sf_rready_low", 32'(rready), 32'd0);

        // AR back-pressure
        cyc();
        inst_req   = 1'b1;
        inst_addr  = 32'h0040_0010;
        inst_cache = 1'b1;
        arready    = 1'b0;
        smp();
        chk("bp_accept", 32'(inst_addr_ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                inst_addr  = 32'h0040_0020;
                inst_cache = 1'b0;
            end
            smp();
            chk("bp_addr_ok", 32'(inst_addr_ok), 32'd0);
            chk("bp_araddr", araddr, 32'h0040_0010);
            chk("bp_arcache", 32'(arcache), 32'hF);
            chk("bp_cnt_hold", 32'(dut.r_cnt), 32'd1);
        end
        cyc();
        arready = 1'b1;
        smp();
        chk("bp_hs_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("bp_perf", perfcnt_ar_stall, 32'd5);
        chk("bp_hs_arvalid", 32'(arvalid), 32'd1);

        // Outstanding limit
        cyc();
        smp();
        chk("lim_resume", 32'(inst_addr_ok), 32'd1);
        cyc();
        inst_addr = 32'h0040_0030;
        smp();
        chk("lim_araddr2", araddr, 32'h0040_0020);
        chk("lim_busy_addr_ok", 32'(inst_addr_ok), 32'd0);
        cyc();
        smp();
        chk("lim_full_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("lim_full_cnt", 32'(dut.r_cnt), 32'd2);
        chk("lim_full_arvalid", 32'(arvalid), 32'd0);
        cyc();
        rvalid = 1'b1;
        rdata  = 32'h1111_1111;
        rresp  = 2'b00;
        sb_q.push_back({1'b0, 32'h1111_1111});
        smp();
        chk("lim_r_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("lim_r_data_ok", 32'(inst_data_ok), 32'd1);
        cyc();
        rvalid   = 1'b0;
        inst_req = 1'b0;
        smp();
        chk("lim_cnt_stays", 32'(dut.r_cnt), 32'd2);
        chk("lim_arvalid3", 32'(arvalid), 32'd1);
        chk("lim_araddr3", araddr, 32'h0040_0030);

        // Error response
        cyc();
        rvalid = 1'b1;
        rdata  = 32'h2222_2222;
        rresp  = 2'b10;
        sb_q.push_back({1'b1, 32'h2222_2222});
        smp();
        chk("err_data_ok", 32'(inst_data_ok), 32'd1);
        chk("err_bus_err", 32'(inst_bus_err), 32'd1);
        cyc();
        rvalid = 1'b0;
        rresp  = 2'b00;
        smp();
        chk("err_data_ok_low", 32'(inst_data_ok), 32'd0);
        chk("err_bus_err_low", 32'(inst_bus_err), 32'd0);
        chk("err_cnt", 32'(dut.r_cnt), 32'd1);
        cyc();
        rvalid = 1'b1;
        rdata  = 32'h3333_3333;
        sb_q.push_back({1'b0, 32'h3333_3333});
        smp();
        chk("last_data_ok", 32'(inst_data_ok), 32'd1);

        // Stray beat with nothing outstanding
        cyc();
        rdata = 32'hDEAD_BEEF;
        smp();
        chk("stray_rready", 32'(rready), 32'd0);
        chk("stray_data_ok", 32'(inst_data_ok), 32'd0);

        // Reset with two requests outstanding and AR busy
        cyc();
        rvalid    = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h0040_0040;
        arready   = 1'b1;
        smp();
        chk("rm_accept1", 32'(inst_addr_ok), 32'd1);
        cyc();
        inst_req = 1'b0;
        smp();
        cyc();
        inst_req  = 1'b1;
        inst_addr = 32'h0040_0050;
        arready   = 1'b0;
        smp();
        chk("rm_accept2", 32'(inst_addr_ok), 32'd1);
        cyc();
        reset  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hBAD0_BAD0;
        smp();
        chk("rm_cnt_pre", 32'(dut.r_cnt), 32'd2);
        chk("rm_arvalid_pre", 32'(arvalid), 32'd1);
        chk("rm_in_rst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rm_in_rst_rready", 32'(rready), 32'd0);
        chk("rm_in_rst_addr_ok", 32'(inst_addr_ok), 32'd0);
        cyc();
        reset = 1'b0;
        smp();
        chk("rm_arvalid", 32'(arvalid), 32'd0);
        chk("rm_cnt", 32'(dut.r_cnt), 32'd0);
        chk("rm_data_ok", 32'(inst_data_ok), 32'd0);
        chk("rm_rready", 32'(rready), 32'd0);
        chk("rm_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rm_perf", perfcnt_ar_stall, 32'd0);
        chk("rm_araddr", araddr, 32'd0);
        cyc();
        inst_req = 1'b0;
        rvalid   = 1'b0;
        smp();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("sb_data_ok_count", 32'(n_dok), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
